// File: rtl/uart_tx_pump_pkg.sv
// Shared types and constants for the FIFO-to-UART transmit pump.
// The byte timeout is derived from the clock and baud rates: two 10-bit characters, rounded to 2^n.
package uart_tx_pump_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWaitStart = 2'd1,
    StWaitDone  = 2'd2,
    StGap       = 2'd3
  } pump_state_e;

  localparam int unsigned DefaultBaud  = 115200;
  localparam int unsigned DefaultClkHz = 12000000;

  // Nearest power of two; ties go to the lower one.
  function automatic int unsigned round_pow2(input int unsigned v);
    int unsigned p;
    p = 1;
    for (int i = 0; i < 31; i++) begin
      if ((p << 1) <= v) p = p << 1;
    end
    return ((v - p) > ((p << 1) - v)) ? (p << 1) : p;
  endfunction

  function automatic int unsigned byte_timeout_cycles(input int unsigned clk_hz,
                                                      input int unsigned baud);
    return round_pow2(2 * 10 * (clk_hz / baud));
  endfunction

  localparam int unsigned DefaultByteTimeout = byte_timeout_cycles(DefaultClkHz, DefaultBaud);

endpackage

// File: rtl/uart_tx_pump_if.sv
// FIFO-side and UART-side signals of the transmit pump.
// The pump takes the master modport; the FIFO/UART environment takes the slave modport.
interface uart_tx_pump_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read;
  logic       u_transmit;
  logic [7:0] u_tx_byte;
  logic       u_is_transmitting;

  modport master (
    input  fifo_empty, fifo_data, u_is_transmitting,
    output fifo_read, u_transmit, u_tx_byte
  );

  modport slave (
    output fifo_empty, fifo_data, u_is_transmitting,
    input  fifo_read, u_transmit, u_tx_byte
  );
endinterface

// File: rtl/tx_gap_timer.sv
// Loadable down-counter; done_o is high during the last counted cycle (count of 1 or 0).
// Load takes priority over counting.
module tx_gap_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             count_en_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q <= WIDTH'(1));

endmodule

// File: rtl/uart_tx_pump.sv
// Pops one FIFO byte at a time into the UART, handshakes on is_transmitting with timeouts,
// and inserts a guard gap after each character.
module uart_tx_pump
  import uart_tx_pump_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned START_TIMEOUT = 8,
  parameter int unsigned BYTE_TIMEOUT  = DefaultByteTimeout
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  uart_tx_pump_if.master       bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] sent_count,
  output logic                 timeout_err,
  input  logic                 clear_err
);

  localparam int unsigned          GapLen    = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
  localparam logic [CNT_WIDTH-1:0] GapLoad   = CNT_WIDTH'(GapLen);
  localparam logic [CNT_WIDTH-1:0] StartLast = CNT_WIDTH'(START_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] ByteLast  = CNT_WIDTH'(BYTE_TIMEOUT - 1);

  pump_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] sent_q, sent_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 fifo_read_q, fifo_read_d;
  logic                 transmit_q, transmit_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 err_set;
  logic                 gap_load;
  logic                 gap_done;

  tx_gap_timer #(
    .WIDTH(CNT_WIDTH)
  ) u_gap_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_i       (gap_load),
    .load_value_i (GapLoad),
    .count_en_i   (state_q == StGap),
    .done_o       (gap_done)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sent_d      = sent_q;
    tx_byte_d   = tx_byte_q;
    fifo_read_d = 1'b0;
    transmit_d  = 1'b0;
    err_set     = 1'b0;
    gap_load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable && !bus.fifo_empty && !bus.u_is_transmitting) begin
          fifo_read_d = 1'b1;
          transmit_d  = 1'b1;
          tx_byte_d   = bus.fifo_data;
          sent_d      = sent_q + CNT_WIDTH'(1);
          cnt_d       = '0;
          state_d     = StWaitStart;
        end
      end
      StWaitStart: begin
        if (bus.u_is_transmitting) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else if (cnt_q == StartLast) begin
          err_set  = 1'b1;
          cnt_d    = '0;
          gap_load = 1'b1;
          state_d  = StGap;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StWaitDone: begin
        if (!bus.u_is_transmitting) begin
          cnt_d    = '0;
          gap_load = 1'b1;
          state_d  = StGap;
        end else if (cnt_q == ByteLast) begin
          err_set  = 1'b1;
          cnt_d    = '0;
          gap_load = 1'b1;
          state_d  = StGap;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StGap: begin
        if (gap_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A timeout firing in the same cycle as clear_err keeps the flag set.
    err_d  = err_set | (err_q & ~clear_err);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sent_q      <= '0;
      tx_byte_q   <= 8'h00;
      fifo_read_q <= 1'b0;
      transmit_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sent_q      <= sent_d;
      tx_byte_q   <= tx_byte_d;
      fifo_read_q <= fifo_read_d;
      transmit_q  <= transmit_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.fifo_read  = fifo_read_q;
  assign bus.u_transmit = transmit_q;
  assign bus.u_tx_byte  = tx_byte_q;
  assign busy           = busy_q;
  assign sent_count     = sent_q;
  assign timeout_err    = err_q;

endmodule

// File: tb/tb_uart_tx_pump.sv
// Scoreboard bench for uart_tx_pump: FIFO and UART behavioural models, expected bytes queued
// at push time and checked by a monitor whenever the pump issues a transmit strobe.
module tb_uart_tx_pump;
  import uart_tx_pump_pkg::*;

  localparam int unsigned GapCyc  = 16;
  localparam int unsigned StartTo = 8;
  localparam int unsigned ByteTo  = 2048;
  localparam int unsigned Period  = 10;

  typedef enum int {ModeNormal, ModeStuckLow, ModeStuckHigh} mode_e;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear_err = 1'b0;
  logic        busy;
  logic [15:0] sent_count;
  logic        timeout_err;
  logic        norm_tx = 1'b0;
  logic        stuck_tx = 1'b0;

  uart_tx_pump_if bus ();
  assign bus.u_is_transmitting = norm_tx | stuck_tx;

  uart_tx_pump #(
    .CNT_WIDTH     (16),
    .GAP_CYCLES    (GapCyc),
    .START_TIMEOUT (StartTo),
    .BYTE_TIMEOUT  (ByteTo)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .bus         (bus),
    .busy        (busy),
    .sent_count  (sent_count),
    .timeout_err (timeout_err),
    .clear_err   (clear_err)
  );

  always #(Period / 2) clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  int          pulse_cnt = 0;
  logic [15:0] model_sent = '0;
  longint      cyc = 0;
  longint      prev_cyc = 0;
  bit          have_prev = 0;
  logic        prev_ut = 1'b0;
  mode_e       mode = ModeNormal;
  bit          rand_timing = 0;
  int          fix_d = 0;
  int          fix_l = 1042;
  int          last_min = 0;
  time         fall_time = 0;
  logic        s_en, s_tx, s_empty;

  function automatic void check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endfunction

  function automatic void check_ge(input string name, input longint act, input longint req);
    tests++;
    if (act < req) begin
      fails++;
      $display("FAIL %s: got %0d, required at least %0d", name, act, req);
    end
  endfunction

  task automatic refresh_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    refresh_fifo();
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name);
    int k = 0;
    while (pulse_cnt < n && k < budget) begin
      tick();
      k++;
    end
    check(name, pulse_cnt, n);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check(name, busy, 0);
  endtask

  // Inputs as seen by the pump at each rising edge.
  always @(posedge clk) begin
    s_en    = enable;
    s_tx    = bus.u_is_transmitting;
    s_empty = bus.fifo_empty;
  end

  // UART model: busy for L cycles starting d cycles after each transmit strobe.
  initial begin
    int d;
    int l;
    forever begin
      tick();
      if (mode != ModeStuckHigh) stuck_tx = 1'b0;
      if (reset_n && bus.u_transmit === 1'b1) begin
        if (mode == ModeNormal) begin
          d = rand_timing ? int'($urandom_range(0, 6)) : fix_d;
          l = rand_timing ? int'($urandom_range(1, 40)) : fix_l;
          repeat (d) tick();
          norm_tx = 1'b1;
          repeat (l) tick();
          norm_tx   = 1'b0;
          fall_time = $time - 1;
          last_min  = 1 + d + l + GapCyc + 1;
        end else begin
          last_min = 0;
          if (mode == ModeStuckHigh) stuck_tx = 1'b1;
        end
      end
    end
  end

  // Monitor and FIFO model.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      have_prev  = 0;
      model_sent = '0;
      prev_ut    = 1'b0;
    end else begin
      if (bus.fifo_read || bus.u_transmit) check("read_with_transmit", bus.fifo_read, bus.u_transmit);
      if (bus.u_transmit) begin
        pulse_cnt++;
        model_sent = model_sent + 16'd1;
        check("no_back_to_back", prev_ut, 0);
        check("pop_conditions", {s_en, s_tx, s_empty}, 3'b100);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got %02h, required no transmit", bus.u_tx_byte);
        end else begin
          check("tx_byte", bus.u_tx_byte, exp_q.pop_front());
        end
        check("sent_count", sent_count, model_sent);
        if (have_prev && last_min > 0) check_ge("pulse_spacing", cyc - prev_cyc, last_min);
        have_prev = 1;
        prev_cyc  = cyc;
      end
      if (bus.fifo_read && fifo_q.size() > 0) void'(fifo_q.pop_front());
      prev_ut = bus.u_transmit;
    end
    refresh_fifo();
  end

  initial begin
    time t_low;
    // Reset with a non-empty FIFO and enable low.
    fifo_q.push_back(8'h77);
    refresh_fifo();
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_fifo_read", bus.fifo_read, 0);
    check("rst_transmit", bus.u_transmit, 0);
    check("rst_tx_byte", bus.u_tx_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_sent", sent_count, 0);
    check("rst_err", timeout_err, 0);
    reset_n = 1'b1;
    repeat (100) tick();
    check("idle_no_pop", pulse_cnt, 0);
    check("idle_busy", busy, 0);
    check("idle_sent", sent_count, 0);
    fifo_q.delete();
    refresh_fifo();

    // Single byte with a 1042-cycle character.
    mode = ModeNormal;
    push(8'hA5);
    enable = 1'b1;
    wait_pulses(1, 50, "single_pop");
    wait_idle(1300, "single_idle");
    t_low = $time - 1;
    check("busy_fall_delay", longint'((t_low - fall_time) / Period), GapCyc + 1);
    check("single_sent", sent_count, 1);

    // Burst of five.
    for (int b = 1; b <= 5; b++) push(8'(b));
    wait_pulses(6, 7000, "burst_pops");
    wait_idle(1300, "burst_idle");
    check("burst_sent", sent_count, 6);
    check("burst_err", timeout_err, 0);

    // UART never raises is_transmitting.
    mode = ModeStuckLow;
    push(8'h11);
    push(8'h22);
    wait_pulses(7, 20, "stuck_low_pop1");
    repeat (StartTo - 1) tick();
    check("start_timeout_early", timeout_err, 0);
    tick();
    check("start_timeout", timeout_err, 1);
    wait_pulses(8, 40, "stuck_low_pop2");
    repeat (StartTo - 1) tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("set_beats_clear", timeout_err, 1);
    wait_idle(40, "stuck_low_idle");
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("clear_err", timeout_err, 0);
    check("stuck_low_sent", sent_count, 8);

    // UART holds is_transmitting high.
    mode = ModeStuckHigh;
    push(8'h33);
    push(8'h44);
    wait_pulses(9, 20, "stuck_high_pop");
    repeat (ByteTo) tick();
    check("byte_timeout_early", timeout_err, 0);
    tick();
    check("byte_timeout", timeout_err, 1);
    repeat (100) tick();
    check("stuck_high_idle", busy, 0);
    check("stuck_high_no_pop", pulse_cnt, 9);
    mode = ModeNormal;
    wait_pulses(10, 1300, "release_pop");
    wait_idle(1300, "release_idle");
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;

    // Random bytes, random UART timing, enable toggling.
    rand_timing = 1;
    for (int i = 0; i < 24; i++) begin
      push(8'($urandom));
      repeat ($urandom_range(0, 40)) tick();
      if ($urandom_range(0, 3) == 0) enable = ~enable;
    end
    enable = 1'b1;
    wait_pulses(34, 5000, "random_pops");
    wait_idle(200, "random_idle");
    check("random_drained", exp_q.size(), 0);
    check("random_err", timeout_err, 0);

    // Reset while a character is in flight.
    rand_timing = 0;
    push(8'h55);
    push(8'h66);
    push(8'h77);
    wait_pulses(35, 20, "midrst_pop");
    repeat (100) tick();
    check("midrst_busy_before", busy, 1);
    reset_n = 1'b0;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_sent", sent_count, 0);
    check("midrst_err", timeout_err, 0);
    check("midrst_tx_byte", bus.u_tx_byte, 0);
    reset_n = 1'b1;
    wait_pulses(37, 3500, "midrst_resume");
    wait_idle(1300, "midrst_idle");
    check("midrst_sent_after", sent_count, 2);
    check("midrst_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
